// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder, CHUNK bits per clock from the LSB, with start/busy/done handshake.
// Define CHUNKED_ADDER_SUBTRACT_EN to add the sub input (a + ~b + cin).
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNKED_ADDER_SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, shadow_q, shadow_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] b_in;
    logic [CHUNK-1:0] ca, cb, psum;
    logic             c_out;

    always_comb begin
        b_in = b;
`ifdef CHUNKED_ADDER_SUBTRACT_EN
        b_in = sub ? ~b : b;
`endif
        ca = a_q[idx_q*CHUNK +: CHUNK];
        cb = b_q[idx_q*CHUNK +: CHUNK];
        {c_out, psum} = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry_q};
        state_d  = state_q == DONE ? IDLE : state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        if (state_q == RUN) begin
            shadow_d[idx_q*CHUNK +: CHUNK] = psum;
            carry_d = c_out;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IW'(NCHUNK - 1)) begin
                sum_d   = shadow_d;
                cout_d  = c_out;
                // carry into the MSB is recovered from the MSB sum bit
                ovf_d   = (ca[CHUNK-1] ^ cb[CHUNK-1] ^ psum[CHUNK-1]) ^ c_out;
                state_d = DONE;
            end
        end
        if (state_q != RUN && start) begin
            a_d     = a;
            b_d     = b_in;
            carry_d = cin;
            idx_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            shadow_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = state_q == RUN;
    assign done     = state_q == DONE;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule
